// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM / first-order sigma-delta DAC with a shared period counter.
// Define PWM_DAC_SIGMA_DELTA_EN to build the sigma-delta mode and accumulators.
module pwm_dac_multi #(
    parameter int NUM_CH        = 2,
    parameter int DATA_WIDTH    = 12,
    parameter int COUNTER_WIDTH = 10,
    parameter int OFFSET        = 512
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic                         mode,
    output logic                         frame_start,
    output logic [NUM_CH-1:0]            pwm_out
);
    localparam int CW = COUNTER_WIDTH;

    logic [CW-1:0]         count;
    logic                  boundary;
    logic                  accept;
    logic                  pending_full;
    logic [CW-1:0]         pending [NUM_CH];
    logic [CW-1:0]         active  [NUM_CH];
    logic [DATA_WIDTH-1:0] sample_sum [NUM_CH];
    logic                  mode_active;
    logic [NUM_CH-1:0]     sd_bit;

    assign boundary   = &count;
    assign data_ready = !pending_full;
    assign accept     = data_valid && data_ready;

    // Offset addition wraps; only the low CW bits become the duty code.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sample_sum[c] = data_in[c*DATA_WIDTH +: DATA_WIDTH] + DATA_WIDTH'(OFFSET);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            frame_start <= 1'b0;
        end else begin
            count       <= count + 1'b1;
            frame_start <= (count == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_full <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pending[c] <= '0;
                active[c]  <= '0;
            end
        end else begin
            // Drain and accept are exclusive: accept needs the buffer empty.
            if (boundary && pending_full) begin
                pending_full <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    active[c] <= pending[c];
                end
            end
            if (accept) begin
                pending_full <= 1'b1;
                for (int c = 0; c < NUM_CH; c++) begin
                    pending[c] <= sample_sum[c][CW-1:0];
                end
            end
        end
    end

`ifdef PWM_DAC_SIGMA_DELTA_EN
    logic [CW-1:0] acc     [NUM_CH];
    logic [CW:0]   acc_sum [NUM_CH];
    logic          mode_switch;

    assign mode_switch = boundary && (mode != mode_active);

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_sum[c] = {1'b0, acc[c]} + {1'b0, active[c]};
            sd_bit[c]  = acc_sum[c][CW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_active <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            if (boundary) begin
                mode_active <= mode;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (mode_switch) begin
                    acc[c] <= '0;
                end else if (mode_active) begin
                    acc[c] <= acc_sum[c][CW-1:0];
                end
            end
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign mode_active = 1'b0;
    assign sd_bit      = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pwm_out[c] <= mode_active ? sd_bit[c] : (count < active[c]);
            end
        end
    end
endmodule

// File: tb/tb_pwm_dac_multi.sv
// Scoreboard bench for pwm_dac_multi: a frame-level reference model predicts every output cycle.
module tb_pwm_dac_multi;
    localparam int NUM_CH = 2;
    localparam int DW     = 12;
    localparam int CW     = 10;
    localparam int OFFSET = 512;
    localparam int N      = 1 << CW;
    localparam int W      = NUM_CH * DW;

    typedef logic [NUM_CH-1:0][CW-1:0] duty_vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [W-1:0]      data_in = '0;
    logic              data_valid = 1'b0;
    logic              mode = 1'b0;
    logic              data_ready;
    logic              frame_start;
    logic [NUM_CH-1:0] pwm_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_dac_multi #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .OFFSET(OFFSET)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .mode(mode), .frame_start(frame_start), .pwm_out(pwm_out)
    );

    // Reference model state: position in frame, applied duties, pending queue, SD residues.
    int                m_t = 0;
    duty_vec_t         m_act = '0;
    duty_vec_t         m_pend[$];
    int                m_phase[NUM_CH] = '{default: 0};
    bit                m_mode = 1'b0;
    logic [NUM_CH-1:0] e_pwm;
    logic              e_fs;
    logic [NUM_CH+1:0] exp_q[$];

    function automatic duty_vec_t to_duty(input logic [W-1:0] d);
        duty_vec_t r;
        for (int c = 0; c < NUM_CH; c++) begin
            int s;
            int v;
            s = int'($signed(d[c*DW +: DW]));
            v = ((s + OFFSET) % N + N) % N;
            r[c] = CW'(v);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input int a, input int b);
        return {DW'(b), DW'(a)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0;
            m_act = '0;
            m_pend.delete();
            m_mode = 1'b0;
            for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
            exp_q.delete();
        end else begin
            bit acc_now;
            acc_now = data_valid && (m_pend.size() == 0);
            for (int c = 0; c < NUM_CH; c++) begin
                if (m_mode) begin
                    e_pwm[c]   = (m_phase[c] + int'(m_act[c])) >= N;
                    m_phase[c] = (m_phase[c] + int'(m_act[c])) % N;
                end else begin
                    e_pwm[c] = m_t < int'(m_act[c]);
                end
            end
            if (m_t == N - 1) begin
                if (m_pend.size() > 0) m_act = m_pend.pop_front();
`ifdef PWM_DAC_SIGMA_DELTA_EN
                if (mode != m_mode) begin
                    for (int c = 0; c < NUM_CH; c++) m_phase[c] = 0;
                end
                m_mode = mode;
`endif
            end
            if (acc_now) m_pend.push_back(to_duty(data_in));
            e_fs = (m_t == 0);
            m_t  = (m_t + 1) % N;
            exp_q.push_back({e_pwm, e_fs, m_pend.size() == 0});
        end
    end

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            logic [NUM_CH+1:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({pwm_out, frame_start, data_ready} !== e) begin
                errors++;
                $display("FAIL cycle t=%0t: got pwm=%b fs=%b ready=%b, expected pwm=%b fs=%b ready=%b",
                         $time, pwm_out, frame_start, data_ready,
                         e[NUM_CH+1:2], e[1], e[0]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [W-1:0] v);
        data_in = v;
        data_valid = 1'b1;
        cyc(1);
        data_valid = 1'b0;
    endtask

    task automatic wait_pos(input int pos);
        int k;
        k = 0;
        while (m_t != pos && k < N + 4) begin
            cyc(1);
            k++;
        end
        chk("wait_pos_timeout", int'(m_t == pos), 1);
    endtask

    task automatic count_frame(input string name, input int want0, input int want1);
        int k;
        int hi0;
        int hi1;
        k = 0;
        hi0 = 0;
        hi1 = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && k < 2 * N) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_fs_timeout"}, int'(frame_start === 1'b1), 1);
        for (int i = 0; i < N; i++) begin
            if (i > 0) @(negedge clk);
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
        end
        chk({name, "_ch0_highs"}, hi0, want0);
        chk({name, "_ch1_highs"}, hi1, want1);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_ready", int'(data_ready), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(3);

        // Centred and quarter-up samples: duties 512 and 768.
        pulse(mk(0, 256));
        cyc(N + 4);
        count_frame("duty_512_768", 512, 768);

        // Extremes: duty 0 and duty 1023.
        pulse(mk(-512, 511));
        cyc(N + 4);
        count_frame("duty_0_1023", 0, 1023);

        // Continuous valid with changing data: one accept per frame, in order.
        data_valid = 1'b1;
        for (int i = 0; i < 4 * N; i++) begin
            data_in = W'($urandom());
            cyc(1);
        end
        data_valid = 1'b0;
        cyc(2 * N);

        // Accept on the boundary cycle itself: must wait for the following boundary.
        wait_pos(N - 1);
        pulse(mk(100, -100));
        chk("bnd_ready_low", int'(data_ready), 0);
        cyc(N + 4);
        count_frame("bnd_applied", 612, 412);

        // Mode selection with duty 256; mode change mid-frame.
        pulse(mk(-256, -256));
        cyc(300);
        mode = 1'b1;
        cyc(N + 4);
        count_frame("mode_duty_256", 256, 256);
        for (int i = 0; i < 8; i++) begin
            cyc($urandom_range(50, 700));
            mode = 1'($urandom());
            if (m_pend.size() == 0) pulse(W'($urandom()));
        end
        mode = 1'b0;
        cyc(2 * N + 4);

        // Reset mid-frame with a pending sample.
        wait_pos(400);
        pulse(mk(300, 300));
        cyc(10);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_pwm", int'(pwm_out), 0);
        chk("midrst_fs", int'(frame_start), 0);
        chk("midrst_ready", int'(data_ready), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(N + 4);
        count_frame("after_rst", 0, 0);

        cyc(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
